// File: rtl/panda_cw_sequencer.sv
// Programmable control-word sequencer: replays stored control words,
// immediates and load-data values into the datapath in run-once, loop
// or single-step mode, with abort and rejected-start reporting.
module panda_cw_sequencer #(
  parameter int unsigned CW_WIDTH   = 28,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_W      = $clog2(DEPTH + 1),
  parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_we_i,
  input  logic [IDX_W-1:0]      load_addr_i,
  input  logic [CW_WIDTH-1:0]   load_cw_i,
  input  logic [DATA_WIDTH-1:0] load_imm_i,
  input  logic [DATA_WIDTH-1:0] load_rdata_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic [1:0]            mode_i,
  input  logic                  start_i,
  input  logic                  step_i,
  input  logic                  abort_i,
  output logic [CW_WIDTH-1:0]   cw_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  valid_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [15:0]           loop_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP
  } state_e;

  typedef enum logic [1:0] {
    MODE_ONCE = 2'd0,
    MODE_LOOP = 2'd1,
    MODE_STEP = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Program store (not reset)
  logic [CW_WIDTH-1:0]   mem_cw    [DEPTH];
  logic [DATA_WIDTH-1:0] mem_imm   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata [DEPTH];

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [LEN_W-1:0]      len_q, len_d;
  // ptr_q is the index of the next entry to issue; equals len_q once the
  // last entry has gone out.
  logic [LEN_W-1:0]      ptr_q, ptr_d;

  logic [CW_WIDTH-1:0]   cw_q, cw_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [15:0]           loop_q, loop_d;

  logic                  issue;
  logic [IDX_W-1:0]      rd_sel;
  logic                  start_ok;
  logic                  at_end;

  assign start_ok = start_i && (len_i != '0) && (len_i <= LEN_W'(DEPTH))
                    && (mode_i != MODE_RSVD);
  assign at_end   = (ptr_q == len_q);

  // Program store writes, accepted only while idle
  always_ff @(posedge clk_i) begin
    if (load_we_i && (state_q == IDLE)) begin
      mem_cw[load_addr_i]    <= load_cw_i;
      mem_imm[load_addr_i]   <= load_imm_i;
      mem_rdata[load_addr_i] <= load_rdata_i;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mode_q  <= MODE_ONCE;
      len_q   <= '0;
      ptr_q   <= '0;
      cw_q    <= '0;
      imm_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      loop_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      cw_q    <= cw_d;
      imm_q   <= imm_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
      loop_q  <= loop_d;
    end
  end

  // Next-state, issue selection and output values
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    issue   = 1'b0;
    rd_sel  = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (start_ok) begin
            len_d  = len_i;
            mode_d = mode_e'(mode_i);
            loop_d = '0;
            if (mode_i == MODE_STEP) begin
              state_d = STEP;
              ptr_d   = '0;
            end else begin
              state_d = RUN;
              issue   = 1'b1;
              rd_sel  = '0;
              ptr_d   = LEN_W'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (at_end) begin
          if (mode_q == MODE_LOOP) begin
            issue  = 1'b1;
            rd_sel = '0;
            ptr_d  = LEN_W'(1);
            loop_d = loop_q + 16'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          issue  = 1'b1;
          rd_sel = IDX_W'(ptr_q);
          ptr_d  = ptr_q + LEN_W'(1);
        end
      end
      STEP: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (at_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (step_i) begin
          issue  = 1'b1;
          rd_sel = IDX_W'(ptr_q);
          ptr_d  = ptr_q + LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = issue;
    if (issue) begin
      cw_d    = mem_cw[rd_sel];
      imm_d   = mem_imm[rd_sel];
      rdata_d = mem_rdata[rd_sel];
      idx_d   = rd_sel;
    end else begin
      cw_d    = '0;
      imm_d   = '0;
      rdata_d = '0;
      idx_d   = '0;
    end
  end

  assign cw_o       = cw_q;
  assign imm_o      = imm_q;
  assign rdata_o    = rdata_q;
  assign valid_o    = valid_q;
  assign idx_o      = idx_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign loop_cnt_o = loop_q;

endmodule

// File: tb/tb_panda_cw_sequencer.sv
// Directed, table-driven bench for panda_cw_sequencer.
module tb_panda_cw_sequencer;

  localparam int unsigned CW_WIDTH   = 28;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned LEN_W      = 5;
  localparam int unsigned IDX_W      = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  load_we_i;
  logic [IDX_W-1:0]      load_addr_i;
  logic [CW_WIDTH-1:0]   load_cw_i;
  logic [DATA_WIDTH-1:0] load_imm_i;
  logic [DATA_WIDTH-1:0] load_rdata_i;
  logic [LEN_W-1:0]      len_i;
  logic [1:0]            mode_i;
  logic                  start_i;
  logic                  step_i;
  logic                  abort_i;
  logic [CW_WIDTH-1:0]   cw_o;
  logic [DATA_WIDTH-1:0] imm_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  valid_o;
  logic [IDX_W-1:0]      idx_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [15:0]           loop_cnt_o;

  panda_cw_sequencer #(
    .CW_WIDTH  (CW_WIDTH),
    .DEPTH     (DEPTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_we_i   (load_we_i),
    .load_addr_i (load_addr_i),
    .load_cw_i   (load_cw_i),
    .load_imm_i  (load_imm_i),
    .load_rdata_i(load_rdata_i),
    .len_i       (len_i),
    .mode_i      (mode_i),
    .start_i     (start_i),
    .step_i      (step_i),
    .abort_i     (abort_i),
    .cw_o        (cw_o),
    .imm_o       (imm_o),
    .rdata_o     (rdata_o),
    .valid_o     (valid_o),
    .idx_o       (idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .loop_cnt_o  (loop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start;
    logic [1:0]  mode;
    logic [4:0]  len;
    logic        step;
    logic        abort;
    logic        ev;
    logic [3:0]  eidx;
    logic        edone;
    logic        eerr;
    logic        ebusy;
    logic [15:0] eloop;
  } vec_t;

  vec_t vecs[$];

  logic [CW_WIDTH-1:0]   exp_cw    [DEPTH];
  logic [DATA_WIDTH-1:0] exp_imm   [DEPTH];
  logic [DATA_WIDTH-1:0] exp_rdata [DEPTH];

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic ev, input logic [3:0] eidx,
                           input logic edone, input logic eerr, input logic ebusy,
                           input logic [15:0] eloop);
    chk({nm, ".valid"}, 64'(valid_o), 64'(ev));
    chk({nm, ".idx"},   64'(idx_o),   ev ? 64'(eidx) : 64'd0);
    chk({nm, ".cw"},    64'(cw_o),    ev ? 64'(exp_cw[eidx]) : 64'd0);
    chk({nm, ".imm"},   64'(imm_o),   ev ? 64'(exp_imm[eidx]) : 64'd0);
    chk({nm, ".rdata"}, 64'(rdata_o), ev ? 64'(exp_rdata[eidx]) : 64'd0);
    chk({nm, ".done"},  64'(done_o),  64'(edone));
    chk({nm, ".err"},   64'(err_o),   64'(eerr));
    chk({nm, ".busy"},  64'(busy_o),  64'(ebusy));
    chk({nm, ".loop"},  64'(loop_cnt_o), 64'(eloop));
  endtask

  function automatic vec_t mk(input logic start, input logic [1:0] mode, input logic [4:0] len,
                              input logic step, input logic abort, input logic ev,
                              input logic [3:0] eidx, input logic edone, input logic eerr,
                              input logic ebusy, input logic [15:0] eloop);
    vec_t v;
    v.start = start; v.mode = mode; v.len = len; v.step = step; v.abort = abort;
    v.ev = ev; v.eidx = eidx; v.edone = edone; v.eerr = eerr; v.ebusy = ebusy;
    v.eloop = eloop;
    return v;
  endfunction

  task automatic load(input int unsigned a, input logic [CW_WIDTH-1:0] cw,
                      input logic [DATA_WIDTH-1:0] imm, input logic [DATA_WIDTH-1:0] rd);
    load_we_i    = 1'b1;
    load_addr_i  = IDX_W'(a);
    load_cw_i    = cw;
    load_imm_i   = imm;
    load_rdata_i = rd;
    tick();
    load_we_i    = 1'b0;
  endtask

  task automatic run_once(input string nm, input int unsigned len);
    start_i = 1'b1; mode_i = 2'd0; len_i = LEN_W'(len);
    tick();
    start_i = 1'b0;
    check_out({nm, ".e0"}, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 16'd0);
    for (int unsigned i = 1; i < len; i++) begin
      tick();
      check_out({nm, ".e"}, 1'b1, 4'(i), 1'b0, 1'b0, 1'b1, 16'd0);
    end
    tick();
    check_out({nm, ".done"}, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'd0);
    tick();
    check_out({nm, ".idle"}, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_WIDTH-1:0] imm_tab [8];
    imm_tab = '{32'd0, 32'd4, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd8};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      exp_cw[i]    = 28'h0A8_8001 + CW_WIDTH'(i) * 28'h001_0203;
      exp_imm[i]   = (i < 8) ? imm_tab[i] : DATA_WIDTH'(i) * 32'h100;
      exp_rdata[i] = (i == 0) ? 32'd3284 : (i == 1) ? 32'd5392 : 32'd1000 + DATA_WIDTH'(i) * 7;
    end

    rst_ni = 1'b0;
    load_we_i = 1'b0; load_addr_i = '0; load_cw_i = '0; load_imm_i = '0; load_rdata_i = '0;
    len_i = '0; mode_i = '0; start_i = 1'b0; step_i = 1'b0; abort_i = 1'b0;
    #3;
    check_out("reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    tick();

    for (int unsigned i = 0; i < DEPTH; i++) load(i, exp_cw[i], exp_imm[i], exp_rdata[i]);

    // run-once, len 8
    vecs.push_back(mk(1, 2'd0, 5'd8, 0, 0, 1, 4'd0, 0, 0, 1, 16'd0));
    for (int unsigned i = 1; i < 8; i++)
      vecs.push_back(mk(0, 2'd0, 5'd0, 0, 0, 1, 4'(i), 0, 0, 1, 16'd0));
    vecs.push_back(mk(0, 2'd0, 5'd0, 0, 0, 0, 4'd0, 1, 0, 0, 16'd0));
    vecs.push_back(mk(0, 2'd0, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 16'd0));
    // loop, len 3, abort during the 7th valid cycle
    vecs.push_back(mk(1, 2'd1, 5'd3, 0, 0, 1, 4'd0, 0, 0, 1, 16'd0));
    for (int unsigned i = 1; i < 7; i++)
      vecs.push_back(mk(0, 2'd0, 5'd0, 0, 0, 1, 4'(i % 3), 0, 0, 1, 16'(i / 3)));
    vecs.push_back(mk(0, 2'd0, 5'd0, 0, 1, 0, 4'd0, 0, 0, 0, 16'd2));
    vecs.push_back(mk(0, 2'd0, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 16'd2));
    // rejected starts; step/abort ignored while idle
    vecs.push_back(mk(1, 2'd0, 5'd0, 0, 0, 0, 4'd0, 0, 1, 0, 16'd2));
    vecs.push_back(mk(0, 2'd0, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 16'd2));
    vecs.push_back(mk(1, 2'd0, 5'd17, 0, 0, 0, 4'd0, 0, 1, 0, 16'd2));
    vecs.push_back(mk(0, 2'd0, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 16'd2));
    vecs.push_back(mk(1, 2'd3, 5'd3, 0, 0, 0, 4'd0, 0, 1, 0, 16'd2));
    vecs.push_back(mk(0, 2'd0, 5'd0, 0, 0, 0, 4'd0, 0, 0, 0, 16'd2));
    vecs.push_back(mk(0, 2'd0, 5'd0, 1, 1, 0, 4'd0, 0, 0, 0, 16'd2));

    foreach (vecs[k]) begin
      start_i = vecs[k].start; mode_i = vecs[k].mode; len_i = vecs[k].len;
      step_i = vecs[k].step; abort_i = vecs[k].abort;
      tick();
      check_out($sformatf("vec%0d", k), vecs[k].ev, vecs[k].eidx, vecs[k].edone,
                vecs[k].eerr, vecs[k].ebusy, vecs[k].eloop);
    end
    start_i = 1'b0; step_i = 1'b0; abort_i = 1'b0;

    // full-depth run
    run_once("full", DEPTH);

    // step mode, len 2, spaced pulses
    start_i = 1'b1; mode_i = 2'd2; len_i = 5'd2;
    tick(); start_i = 1'b0;
    check_out("step.start", 0, 4'd0, 0, 0, 1, 16'd0);
    repeat (3) begin tick(); check_out("step.gap0", 0, 4'd0, 0, 0, 1, 16'd0); end
    step_i = 1'b1; tick(); step_i = 1'b0;
    check_out("step.e0", 1, 4'd0, 0, 0, 1, 16'd0);
    repeat (3) begin tick(); check_out("step.gap1", 0, 4'd0, 0, 0, 1, 16'd0); end
    step_i = 1'b1; tick();
    check_out("step.e1", 1, 4'd1, 0, 0, 1, 16'd0);
    tick();
    check_out("step.done", 0, 4'd0, 1, 0, 0, 16'd0);
    tick(); step_i = 1'b0;
    check_out("step.after", 0, 4'd0, 0, 0, 0, 16'd0);

    // step and abort together
    start_i = 1'b1; mode_i = 2'd2; len_i = 5'd2;
    tick(); start_i = 1'b0;
    check_out("sabort.start", 0, 4'd0, 0, 0, 1, 16'd0);
    step_i = 1'b1; abort_i = 1'b1; tick(); step_i = 1'b0; abort_i = 1'b0;
    check_out("sabort.edge", 0, 4'd0, 0, 0, 0, 16'd0);
    tick();
    check_out("sabort.after", 0, 4'd0, 0, 0, 0, 16'd0);

    // held step issues consecutive entries
    start_i = 1'b1; mode_i = 2'd2; len_i = 5'd3;
    tick(); start_i = 1'b0; step_i = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick(); check_out("shold", 1, 4'(i), 0, 0, 1, 16'd0);
    end
    step_i = 1'b0; tick();
    check_out("shold.done", 0, 4'd0, 1, 0, 0, 16'd0);

    // write while busy is dropped; write while idle is used next run
    start_i = 1'b1; mode_i = 2'd0; len_i = 5'd3;
    tick(); start_i = 1'b0;
    check_out("wr.e0", 1, 4'd0, 0, 0, 1, 16'd0);
    load(1, 28'h0FF_FFFF, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    check_out("wr.e1", 1, 4'd1, 0, 0, 1, 16'd0);
    tick(); check_out("wr.e2", 1, 4'd2, 0, 0, 1, 16'd0);
    tick(); check_out("wr.done", 0, 4'd0, 1, 0, 0, 16'd0);
    run_once("wr.rerun", 3);
    exp_cw[1] = 28'h0FF_FFFF; exp_imm[1] = 32'hDEAD_BEEF; exp_rdata[1] = 32'hCAFE_F00D;
    load(1, exp_cw[1], exp_imm[1], exp_rdata[1]);
    run_once("wr.new", 3);

    // asynchronous reset during a loop run
    start_i = 1'b1; mode_i = 2'd1; len_i = 5'd2;
    tick(); start_i = 1'b0;
    tick(); tick();
    check_out("rst.pre", 1, 4'd0, 0, 0, 1, 16'd1);
    #1 rst_ni = 1'b0;
    #1 check_out("rst.async", 0, 4'd0, 0, 0, 0, 16'd0);
    #2 rst_ni = 1'b1;
    tick();
    check_out("rst.idle", 0, 4'd0, 0, 0, 0, 16'd0);
    run_once("rst.replay", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/panda_cw_sequencer.md
Name: panda_cw_sequencer

Overview:
Programmable control-word sequencer that replays a stored list of datapath control words, immediates and load-data values into panda_sc_datapath, one entry per issue.
- Generalises hand-driven control-word stimulus: parametrised control-word and data widths, parametrised depth, and three play modes (run-once, loop, single-step).
- Adds abort and error reporting.
- Sits between a loader (bench or debug port) and the datapath control/imm/rdata inputs.

Parameters:
CW_WIDTH, 28, control-word width.
DEPTH, 16, number of entries in the program store; must be at least 2.
DATA_WIDTH, 32, width of the imm and rdata fields.
LEN_W, $clog2(DEPTH+1), width of the length input (derived).
IDX_W, $clog2(DEPTH), width of the index (derived).

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, asynchronous, active-low.
load_we_i  in  1  program-store write enable.
load_addr_i  in  IDX_W  write address.
load_cw_i  in  CW_WIDTH  control word to store.
load_imm_i  in  DATA_WIDTH  immediate to store.
load_rdata_i  in  DATA_WIDTH  load-data value to store.
len_i  in  LEN_W  number of entries to play; sampled on start.
mode_i  in  2  play mode: 0 run-once, 1 loop, 2 single-step, 3 reserved (treated as error); sampled on start.
start_i  in  1  start request.
step_i  in  1  advance one entry in step mode.
abort_i  in  1  stop playback.
cw_o  out  CW_WIDTH  issued control word; all-zero means NOP.
imm_o  out  DATA_WIDTH  issued immediate.
rdata_o  out  DATA_WIDTH  issued load data.
valid_o  out  1  an entry is being issued this cycle.
idx_o  out  IDX_W  index of the entry on cw_o.
busy_o  out  1  sequencer is not IDLE.
done_o  out  1  one-cycle completion pulse.
err_o  out  1  one-cycle pulse: rejected start.
loop_cnt_o  out  16  completed loop passes.

Behaviour:
Reset and outputs
- Reset: every output is 0 and state is IDLE. The program store is not reset; its contents are undefined until written.
- All outputs are registered.
- Whenever valid_o=0: cw_o, imm_o, rdata_o and idx_o are 0.

Program store
- An entry is written at the clock edge where load_we_i=1 and busy_o=0.
- Writes while busy_o=1 are dropped.
- A write takes effect for the next start.

States: IDLE, RUN, STEP.

IDLE
- start_i with 1 <= len_i <= DEPTH and mode_i != 3 latches len and mode, sets idx=0, and clears loop_cnt_o.
  - Mode 0 or 1: issue entry 0 at the same edge and go to RUN.
  - Mode 2: go to STEP and issue nothing.
- start_i with an invalid len or mode: err_o=1 for one cycle; stay in IDLE.
- abort_i and step_i are ignored in IDLE.

RUN
- One entry is issued per cycle, with no gaps. The entry at idx is on the outputs during the cycle after its issue edge.
- After the cycle issuing entry len-1, at the next edge:
  - Mode 0: valid_o=0, done_o=1 for one cycle, go to IDLE.
  - Mode 1: issue entry 0 with no bubble, loop_cnt_o += 1 (wraps at 2^16), stay in RUN.
- start_i is ignored.

STEP
- Each edge with step_i=1 issues the next entry; valid_o=1 for exactly that one cycle, then NOP.
- After entry len-1 has been issued, the next edge gives done_o=1 and goes to IDLE. Steps arriving during that done cycle are ignored.
- A step held high for consecutive cycles issues consecutive entries.

Abort
- abort_i in RUN or STEP has the highest priority.
- At that edge: valid_o=0, go to IDLE, no done_o.
- Abort wins over a simultaneous step_i or wrap.
- loop_cnt_o holds its value until the next start.

Reset mid-operation
- Asserting rst_ni low during playback forces all outputs to 0 immediately, without waiting for a clock edge.
- The sequencer returns to IDLE and playback does not resume.

Latency
- start edge to first valid_o: 0 cycles in RUN (entry visible right after the start edge).
- Last entry to done_o: 1 cycle.

Test Plan:
1. Load 8 entries (e.g. cw entry 0 = 28'h0A8_8001, imm {0,4,0,1,0,0,0,8}, rdata entry 0 = 3284, entry 1 = 5392), len=8, mode=0, pulse start -> 8 consecutive valid_o cycles with idx_o 0..7 and the matching cw/imm/rdata; done_o high for 1 cycle the cycle after idx 7; busy_o then 0.
2. Loop mode, len=3 -> idx_o 0,1,2,0,1,2,0 with no gap; loop_cnt_o reaches 2; abort during the 7th valid cycle -> next cycle valid_o=0 and cw_o=0, done_o never asserted, loop_cnt_o stays 2.
3. Step mode, len=2; step_i pulses separated by 3 idle cycles -> exactly one valid cycle per pulse (idx 0 then idx 1), cw_o=0 in between; done_o 1 cycle after the second issue; step_i and abort_i high together -> abort wins, no issue.
4. start with len=0, len=DEPTH+1, and mode=3 -> err_o pulses once each, busy_o stays 0, no valid_o.
5. During a mode-0 run, write entry 1 with new data -> current and next run both issue the original entry 1; after IDLE, rewrite entry 1 and rerun -> new value issued.
6. Drive rst_ni low mid-RUN between clock edges -> all outputs 0 before the next edge; after release, state is IDLE and a valid start replays from idx 0.
